// File: rtl/pix_reduce_n_pkg.sv
// Shared types and constants for the pixel colour-reduce pipeline.
// Holds the config record, channel-select codes and the channel-selection helper.
package pix_pkg;

  typedef struct packed {
    logic [2:0] shift;
    logic [1:0] sel;
    logic       bright;
    logic       swap_gb;
  } cfg_t;

  localparam logic [1:0] SEL_ALL = 2'd0;
  localparam logic [1:0] SEL_R   = 2'd1;
  localparam logic [1:0] SEL_G   = 2'd2;
  localparam logic [1:0] SEL_B   = 2'd3;

  // Channel position within a pixel, counted from the LSB end of {R,G,B}.
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  typedef enum logic {
    STG_BRIGHT = 1'b0,
    STG_QUANT  = 1'b1
  } stage_t;

  function automatic logic chan_selected(input logic [1:0] sel, input int ch);
    logic hit;
    case (sel)
      SEL_R:   hit = (ch == CH_R);
      SEL_G:   hit = (ch == CH_G);
      SEL_B:   hit = (ch == CH_B);
      default: hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pix_reduce_n_chan_proc.sv
// Single-pixel combinational processing: saturating brighten or masked quantise,
// chosen by the stage input. Quantise also applies the optional G/B swap.
module pix_chan_proc
  import pix_pkg::*;
#(
  parameter int CBITS       = 6,
  parameter int BRIGHT_STEP = 8
) (
  input  logic               stage,
  input  logic [2:0]         shift,
  input  logic [1:0]         sel,
  input  logic               bright,
  input  logic               swap_gb,
  input  logic [3*CBITS-1:0] pix_in,
  output logic [3*CBITS-1:0] pix_out
);

  function automatic logic [CBITS-1:0] brighten(input logic [CBITS-1:0] c, input logic en);
    logic [CBITS:0] sum;
    sum = {1'b0, c} + (CBITS+1)'(BRIGHT_STEP);
    if (!en) return c;
    return sum[CBITS] ? {CBITS{1'b1}} : sum[CBITS-1:0];
  endfunction

  // Shift amounts beyond CBITS-1 clamp so at least the MSB always survives.
  function automatic logic [CBITS-1:0] quantise(input logic [CBITS-1:0] c, input logic [2:0] s);
    logic [2:0] s_eff;
    s_eff = (int'(s) > CBITS - 1) ? 3'(CBITS - 1) : s;
    return c & ({CBITS{1'b1}} << s_eff);
  endfunction

  logic [CBITS-1:0] res [3];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    pix_out = pix_in;
    for (int ch = 0; ch < 3; ch++) begin
      res[ch] = pix_in[ch*CBITS +: CBITS];
      if (stage == STG_BRIGHT) begin
        res[ch] = brighten(pix_in[ch*CBITS +: CBITS], bright);
      end else if (chan_selected(sel, ch)) begin
        res[ch] = quantise(pix_in[ch*CBITS +: CBITS], shift);
      end
    end
    if (stage == STG_QUANT && swap_gb) begin
      pix_out = {res[CH_R], res[CH_B], res[CH_G]};
    end else begin
      pix_out = {res[CH_R], res[CH_G], res[CH_B]};
    end
  end

endmodule

// File: rtl/pix_reduce_n.sv
// NPIX-wide colour reduce: brighten in stage 1, quantise/swap in stage 2, with a
// valid/ready skid-free two-register pipe and frame-aligned config shadowing.
module pix_reduce_n
  import pix_pkg::*;
#(
  parameter int NPIX        = 2,
  parameter int CBITS       = 6,
  parameter int BRIGHT_STEP = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [NPIX*3*CBITS-1:0] in_pix,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic [NPIX*3*CBITS-1:0] out_pix,
  input  logic                    cfg_change,
  input  logic [2:0]              cfg_shift,
  input  logic [1:0]              cfg_sel,
  input  logic                    cfg_bright,
  input  logic                    cfg_swap_gb,
  output logic                    cfg_pending
);

  localparam int PW = 3 * CBITS;
  localparam int W  = NPIX * PW;

  cfg_t act_cfg, pend_cfg, beat_cfg, new_cfg, s1_cfg;

  logic         s1_valid, s1_sof;
  logic [W-1:0] s1_pix, s1_next, s2_next;
  logic         s2_load, accept, apply_cfg;

  assign s2_load   = !out_valid || out_ready;
  assign in_ready  = !s1_valid || s2_load;
  assign accept    = in_valid && in_ready;
  assign apply_cfg = accept && in_sof && cfg_pending;

  assign new_cfg  = cfg_t'{shift: cfg_shift, sel: cfg_sel, bright: cfg_bright, swap_gb: cfg_swap_gb};
  assign beat_cfg = apply_cfg ? pend_cfg : act_cfg;

  // A cfg_change coinciding with a frame start lands in pending and stays pending,
  // so the later assignment wins.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!reset) begin
      act_cfg     <= '0;
      pend_cfg    <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (apply_cfg) begin
        act_cfg     <= pend_cfg;
        cfg_pending <= 1'b0;
      end
      if (cfg_change) begin
        pend_cfg    <= new_cfg;
        cfg_pending <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    pix_chan_proc #(
      .CBITS       (CBITS),
      .BRIGHT_STEP (BRIGHT_STEP)
    ) u_bright (
      .stage   (STG_BRIGHT),
      .shift   (beat_cfg.shift),
      .sel     (beat_cfg.sel),
      .bright  (beat_cfg.bright),
      .swap_gb (beat_cfg.swap_gb),
      .pix_in  (in_pix[k*PW +: PW]),
      .pix_out (s1_next[k*PW +: PW])
    );

    pix_chan_proc #(
      .CBITS       (CBITS),
      .BRIGHT_STEP (BRIGHT_STEP)
    ) u_quant (
      .stage   (STG_QUANT),
      .shift   (s1_cfg.shift),
      .sel     (s1_cfg.sel),
      .bright  (s1_cfg.bright),
      .swap_gb (s1_cfg.swap_gb),
      .pix_in  (s1_pix[k*PW +: PW]),
      .pix_out (s2_next[k*PW +: PW])
    );
  end

  // Stage 1 only accepts when it is empty or draining into stage 2 this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_pix   <= '0;
      s1_cfg   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sof   <= in_sof;
      s1_pix   <= s1_next;
      s1_cfg   <= beat_cfg;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_pix   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sof <= s1_sof;
        out_pix <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_pix_reduce_n.sv
// Scoreboard bench for pix_reduce_n: directed vectors push expected beats,
// a monitor pops and compares on every output handshake.
module tb_pix_reduce_n;

  localparam int NPIX        = 2;
  localparam int CBITS       = 6;
  localparam int BRIGHT_STEP = 8;
  localparam int W           = NPIX * 3 * CBITS;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_sof;
  logic [W-1:0] in_pix;
  logic         out_valid, out_ready, out_sof;
  logic [W-1:0] out_pix;
  logic         cfg_change, cfg_bright, cfg_swap_gb, cfg_pending;
  logic [2:0]   cfg_shift;
  logic [1:0]   cfg_sel;

  typedef struct {
    logic         sof;
    logic [W-1:0] pix;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   inflight = 0;
  logic rand_mode = 1'b0;
  logic ready_hold = 1'b1;
  logic prev_stall = 1'b0;
  logic prev_sof;
  logic [W-1:0] prev_pix;

  pix_reduce_n #(
    .NPIX        (NPIX),
    .CBITS       (CBITS),
    .BRIGHT_STEP (BRIGHT_STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sof      (in_sof),
    .in_pix      (in_pix),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .out_pix     (out_pix),
    .cfg_change  (cfg_change),
    .cfg_shift   (cfg_shift),
    .cfg_sel     (cfg_sel),
    .cfg_bright  (cfg_bright),
    .cfg_swap_gb (cfg_swap_gb),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [17:0] px(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    return {r, g, b};
  endfunction

  function automatic logic [W-1:0] bt(input logic [17:0] p0, input logic [17:0] p1);
    return {p1, p0};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] p, input logic sof, input logic [W-1:0] exp);
    int   waited;
    logic done;
    exp_t e;
    waited = 0;
    done   = 1'b0;
    in_pix   = p;
    in_sof   = sof;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.sof = sof;
        e.pix = exp;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 200) begin
        fail_now("send_accept");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic cfg_pulse(input logic [2:0] s, input logic [1:0] sl, input logic b, input logic sw);
    cfg_shift   = s;
    cfg_sel     = sl;
    cfg_bright  = b;
    cfg_swap_gb = sw;
    cfg_change  = 1'b1;
    @(posedge clk);
    #1;
    cfg_change = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expects an empty pipe before the send that just returned.
  task automatic check_latency(input string name);
    check({name, "_lat1"}, out_valid, 1'b0);
    @(posedge clk);
    #1;
    check({name, "_lat2"}, out_valid, 1'b1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_hold;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        inflight   = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_pix", out_pix, prev_pix);
          check("stall_sof", out_sof, prev_sof);
        end
        check("in_ready", in_ready, !(inflight == 2 && !out_ready));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = sb.pop_front();
            check("out_pix", out_pix, e.pix);
            check("out_sof", out_sof, e.sof);
          end
        end
        inflight   = inflight + int'(in_valid && in_ready) - int'(out_valid && out_ready);
        prev_stall = out_valid && !out_ready;
        prev_pix   = out_pix;
        prev_sof   = out_sof;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]  r;
    logic [W-1:0] mask, p;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_sof      = 1'b0;
    in_pix      = '0;
    cfg_change  = 1'b0;
    cfg_shift   = '0;
    cfg_sel     = '0;
    cfg_bright  = 1'b0;
    cfg_swap_gb = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sof", out_sof, 1'b0);
    check("rst_out_pix", out_pix, '0);
    check("rst_cfg_pending", cfg_pending, 1'b0);
    cycles(1);
    reset = 1'b1;
    cycles(2);

    // Default config passes data through unchanged.
    p = bt(px(6'h3F, 6'h2A, 6'h15), px(6'h3F, 6'h2A, 6'h15));
    send(p, 1'b1, p);
    check_latency("stream");
    repeat (3) send(p, 1'b0, p);
    drain("stream_drain");

    // Saturating brighten.
    cfg_pulse(3'd0, 2'd0, 1'b1, 1'b0);
    check("bright_pending", cfg_pending, 1'b1);
    send(bt(px(6'h3A, 6'h05, 6'h3F), px(6'h00, 6'h37, 6'h38)), 1'b1,
         bt(px(6'h3F, 6'h0D, 6'h3F), px(6'h08, 6'h3F, 6'h3F)));
    check("bright_applied", cfg_pending, 1'b0);

    // Quantise R only, then clamped shift, then G with swap, then B with brighten.
    cfg_pulse(3'd3, 2'd1, 1'b0, 1'b0);
    send(bt(px(6'h3F, 6'h3F, 6'h3F), px(6'h2D, 6'h17, 6'h09)), 1'b1,
         bt(px(6'h38, 6'h3F, 6'h3F), px(6'h28, 6'h17, 6'h09)));
    cfg_pulse(3'd7, 2'd1, 1'b0, 1'b0);
    send(bt(px(6'h3F, 6'h3F, 6'h3F), px(6'h1F, 6'h3F, 6'h00)), 1'b1,
         bt(px(6'h20, 6'h3F, 6'h3F), px(6'h00, 6'h3F, 6'h00)));
    cfg_pulse(3'd2, 2'd2, 1'b0, 1'b1);
    send(bt(px(6'h3F, 6'h2B, 6'h11), px(6'h15, 6'h07, 6'h3E)), 1'b1,
         bt(px(6'h3F, 6'h11, 6'h28), px(6'h15, 6'h3E, 6'h04)));
    cfg_pulse(3'd1, 2'd3, 1'b1, 1'b0);
    send(bt(px(6'h10, 6'h20, 6'h35), px(6'h3C, 6'h39, 6'h3A)), 1'b1,
         bt(px(6'h18, 6'h28, 6'h3C), px(6'h3F, 6'h3F, 6'h3E)));

    // Frame-boundary shadowing.
    p = bt(px(6'h3F, 6'h2A, 6'h15), px(6'h3F, 6'h2A, 6'h15));
    cfg_pulse(3'd0, 2'd0, 1'b0, 1'b0);
    send(p, 1'b1, p);
    cfg_pulse(3'd4, 2'd0, 1'b0, 1'b0);
    check("mid_pending", cfg_pending, 1'b1);
    send(p, 1'b0, p);
    check("mid_still_pending", cfg_pending, 1'b1);
    send(p, 1'b1, bt(px(6'h30, 6'h20, 6'h10), px(6'h30, 6'h20, 6'h10)));
    check("sof_applied", cfg_pending, 1'b0);
    cfg_shift   = 3'd0;
    cfg_sel     = 2'd0;
    cfg_bright  = 1'b0;
    cfg_swap_gb = 1'b1;
    cfg_change  = 1'b1;
    send(p, 1'b1, bt(px(6'h30, 6'h20, 6'h10), px(6'h30, 6'h20, 6'h10)));
    cfg_change = 1'b0;
    check("simul_pending", cfg_pending, 1'b1);
    send(p, 1'b0, bt(px(6'h30, 6'h20, 6'h10), px(6'h30, 6'h20, 6'h10)));
    send(p, 1'b1, bt(px(6'h3F, 6'h15, 6'h2A), px(6'h3F, 6'h15, 6'h2A)));
    check("simul_applied", cfg_pending, 1'b0);
    drain("shadow_drain");

    // Random backpressure with shift 2 on every channel.
    for (int k = 0; k < NPIX * 3; k++) mask[k*CBITS +: CBITS] = 6'h3C;
    cfg_pulse(3'd2, 2'd0, 1'b0, 1'b0);
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom};
      p = r[W-1:0];
      send(p, (i == 0), p & mask);
    end
    rand_mode  = 1'b0;
    ready_hold = 1'b1;
    drain("bp_drain");

    // Reset with both stages full.
    cfg_pulse(3'd5, 2'd0, 1'b1, 1'b1);
    ready_hold = 1'b0;
    cycles(3);
    p = bt(px(6'h11, 6'h22, 6'h33), px(6'h11, 6'h22, 6'h33));
    send(p, 1'b0, bt(px(6'h10, 6'h20, 6'h30), px(6'h10, 6'h20, 6'h30)));
    send(p, 1'b0, bt(px(6'h10, 6'h20, 6'h30), px(6'h10, 6'h20, 6'h30)));
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_pix", out_pix, '0);
    check("mid_rst_cfg_pending", cfg_pending, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    ready_hold = 1'b1;
    cycles(3);
    p = bt(px(6'h3F, 6'h2A, 6'h15), px(6'h3F, 6'h2A, 6'h15));
    send(p, 1'b1, p);
    check_latency("post_rst");
    check("post_rst_pending", cfg_pending, 1'b0);
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
